cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between three result producers: ALU1, ALU2 and the load/store buffer.
- Each producer gets a small result queue, and the block grants the CDB round-robin.
- Drives the CDB broadcast that the reservation station, ROB and LSB consume (rs_update_flag / rs_commit_rename / rs_value).
- Raises a stall toward issue logic before any queue can overflow, since producers have no backpressure.

Parameters:
- FIFO_DEPTH, 4, entries per source queue (power of two, >=4).
- STALL_MARGIN, 2, issue_stall asserts when any queue count >= FIFO_DEPTH-STALL_MARGIN.
- TAG_W, 4, ROB rename tag width.

Ports:
- clk  input  1  clock, all state on posedge.
- rst  input  1  synchronous active-high reset.
- rdy  input  1  global ready; low = freeze.
- flush  input  1  mispredict flush.
- alu1_valid  input  1  ALU1 result present this cycle.
- alu1_tag  input  TAG_W  ALU1 ROB tag.
- alu1_value  input  32  ALU1 result.
- alu2_valid  input  1  ALU2 result present.
- alu2_tag  input  TAG_W  ALU2 ROB tag.
- alu2_value  input  32  ALU2 result.
- lsb_valid  input  1  LSB load result present.
- lsb_tag  input  TAG_W  LSB ROB tag.
- lsb_value  input  32  LSB result.
- cdb_valid  output  1  broadcast valid.
- cdb_tag  output  TAG_W  broadcast ROB tag.
- cdb_value  output  32  broadcast value.
- cdb_src  output  2  granted source (0 ALU1, 1 ALU2, 2 LSB).
- issue_stall  output  1  combinational near-full indication.
- overflow_err  output  1  sticky, set on enqueue into a full queue.

Behaviour:
- Reset (rst=1 at posedge):
  - All queues empty; cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_src=0, overflow_err=0.
  - RR pointer last=2 (LSB), so first priority order is ALU1>ALU2>LSB.
  - Reset overrides rdy and flush.
- rdy=0: no state change, inputs ignored (results lost), outputs hold.
- Flush (rdy=1, flush=1):
  - All queues cleared; inputs at the same edge dropped.
  - cdb_valid<=0 at that edge.
  - RR pointer and overflow_err unchanged.
  - issue_stall deasserts the cycle after.
- Per-source queue:
  - Circular FIFO with head, tail and count; pointers wrap mod FIFO_DEPTH.
  - Enqueue when x_valid=1 at edge.
  - Dequeue when granted.
  - Simultaneous enqueue+dequeue: count unchanged, both pointers advance.
  - Enqueue while count==FIFO_DEPTH and not dequeuing that edge: entry dropped, overflow_err<=1 (sticky until rst).
- Arbitration:
  - Combinational over non-empty queues; first non-empty source after last, wrapping.
  - Granted head is registered into cdb_tag/cdb_value/cdb_src with cdb_valid<=1; last<=granted.
  - No non-empty queue: cdb_valid<=0, last unchanged, data outputs hold.
- Latency: result sampled at edge E appears on CDB after edge E+1 at the earliest (one queue stage).
- Throughput: one broadcast per cycle; each source gets at least 1 of every 3 grants under contention.
- cdb_valid is high for exactly one cycle per accepted result; no duplicate broadcasts.
- issue_stall = OR over queues of (count >= FIFO_DEPTH-STALL_MARGIN); forced 0 during rst.

Optional Feature:
- Macro: CDB_BYPASS_EN.
- When defined:
  - If the RR winner computed over (queue non-empty OR x_valid) selects a source whose queue is empty, its input is driven to the CDB registers at edge E directly, without enqueueing (latency 0 queue stages).
  - Queue ordering per source is preserved, since bypass happens only when that queue is empty.
- When undefined: all results pass through the queue (behaviour above).

Test Plan:
- Reset, then alu1_valid=1 tag=3 value=0x0000_0011 for one cycle -> cdb_valid high one cycle after next edge, cdb_tag=3, cdb_value=0x11, cdb_src=0; with CDB_BYPASS_EN it appears one cycle earlier.
- All three valid in one cycle (tags 1, 2, 5) -> three consecutive broadcasts in order tags 1, 2, 5 (src 0, 1, 2); then only ALU2 tag=7 -> src 1 broadcast; next three-way contention starts at LSB.
- ALU1 valid on 3 consecutive cycles with CDB continuously contended by ALU2/LSB -> issue_stall rises when ALU1 count reaches 2; no overflow; all 3 ALU1 tags broadcast in order.
- ALU1 valid 6 cycles straight with FIFO_DEPTH=4 under full contention -> overflow_err=1 and stays 1; exactly the dropped tags never appear on the CDB.
- Queues holding 2 entries each, flush=1 with alu2_valid=1 on the same edge -> cdb_valid=0 next cycle, no further broadcasts, ALU2 result dropped, issue_stall=0.
- rdy=0 for 3 cycles with queued entries and alu1_valid=1 -> outputs frozen, no dequeue, ALU1 input ignored; after rdy=1 broadcasts resume in the prior RR order.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the common data bus between ALU1, ALU2 and the
// load/store buffer. Each producer owns a small circular result queue; the
// queue heads are granted round-robin and the winner is registered onto the
// CDB broadcast consumed by the RS, ROB and LSB.
//
// Ports
//   clk, rst          clock / synchronous active-high reset
//   rdy               global ready, low freezes all state
//   flush             mispredict flush: clears queues, drops same-edge inputs
//   alu1_*/alu2_*/lsb_*  producer results (valid, ROB tag, 32-bit value)
//   cdb_valid/tag/value/src  registered broadcast (src: 0 ALU1, 1 ALU2, 2 LSB)
//   issue_stall       combinational near-full indication toward issue
//   overflow_err      sticky, set when a result is dropped at a full queue
//
// Optional build macro CDB_BYPASS_EN: a result arriving while its queue is
// empty may win arbitration in the same cycle and go straight to the CDB
// registers without being enqueued.

module cdb_src_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4,
    parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             enq,
    input  logic             deq,
    input  logic [TAG_W-1:0] din_tag,
    input  logic [31:0]      din_value,
    output logic [TAG_W-1:0] head_tag,
    output logic [31:0]      head_value,
    output logic [CW-1:0]    count,
    output logic             ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [AW-1:0]    head, tail;
    logic [TAG_W-1:0] mem_tag   [FIFO_DEPTH];
    logic [31:0]      mem_value [FIFO_DEPTH];
    logic             full, do_enq, do_deq;

    assign full   = (count == FULL_CNT);
    assign do_deq = deq && (count != '0);
    // A full queue still accepts when it is being drained at the same edge.
    assign do_enq = enq && (!full || do_deq);
    assign ovf    = rdy && !flush && enq && full && !do_deq;

    assign head_tag   = mem_tag[head];
    assign head_value = mem_value[head];

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_enq) begin
                    mem_tag[tail]   <= din_tag;
                    mem_value[tail] <= din_value;
                    tail            <= tail + 1'b1;
                end
                if (do_deq)
                    head <= head + 1'b1;
                case ({do_enq, do_deq})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

module cdb_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STALL_MARGIN = 2,
    parameter int TAG_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             alu1_valid,
    input  logic [TAG_W-1:0] alu1_tag,
    input  logic [31:0]      alu1_value,
    input  logic             alu2_valid,
    input  logic [TAG_W-1:0] alu2_tag,
    input  logic [31:0]      alu2_value,
    input  logic             lsb_valid,
    input  logic [TAG_W-1:0] lsb_tag,
    input  logic [31:0]      lsb_value,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [31:0]      cdb_value,
    output logic [1:0]       cdb_src,
    output logic             issue_stall,
    output logic             overflow_err
);
    localparam int NSRC = 3;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] STALL_LVL = CW'(FIFO_DEPTH - STALL_MARGIN);

    logic [NSRC-1:0]            in_valid;
    logic [NSRC-1:0][TAG_W-1:0] in_tag;
    logic [NSRC-1:0][31:0]      in_value;
    logic [NSRC-1:0][TAG_W-1:0] q_tag;
    logic [NSRC-1:0][31:0]      q_value;
    logic [NSRC-1:0][CW-1:0]    q_count;
    logic [NSRC-1:0]            q_nonempty, req, enq, deq, ovf, near_full;
    logic [1:0]                 last, grant;
    logic                       grant_vld, bypass;
    logic [TAG_W-1:0]           sel_tag;
    logic [31:0]                sel_value;
    int                         arb_idx;

    assign in_valid = {lsb_valid, alu2_valid, alu1_valid};
    assign in_tag   = {lsb_tag, alu2_tag, alu1_tag};
    assign in_value = {lsb_value, alu2_value, alu1_value};

`ifdef CDB_BYPASS_EN
    assign req    = q_nonempty | in_valid;
    assign bypass = grant_vld && !q_nonempty[grant];
`else
    assign req    = q_nonempty;
    assign bypass = 1'b0;
`endif

    // Round-robin: first requester strictly after the last grant, wrapping.
    always_comb begin
        grant     = last;
        grant_vld = 1'b0;
        arb_idx   = 0;
        for (int i = 1; i <= NSRC; i++) begin
            arb_idx = (int'(last) + i) % NSRC;
            if (!grant_vld && req[arb_idx]) begin
                grant_vld = 1'b1;
                grant     = 2'(arb_idx);
            end
        end
    end

    assign sel_tag   = bypass ? in_tag[grant]   : q_tag[grant];
    assign sel_value = bypass ? in_value[grant] : q_value[grant];

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        assign q_nonempty[i] = (q_count[i] != '0);
        assign near_full[i]  = (q_count[i] >= STALL_LVL);
        // A bypassed result goes straight to the CDB and must not also queue.
        assign enq[i] = in_valid[i] && !(bypass && grant == 2'(i));
        assign deq[i] = grant_vld && !bypass && grant == 2'(i);

        cdb_src_fifo #(
            .FIFO_DEPTH(FIFO_DEPTH),
            .TAG_W     (TAG_W),
            .CW        (CW)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .rdy       (rdy),
            .flush     (flush),
            .enq       (enq[i]),
            .deq       (deq[i]),
            .din_tag   (in_tag[i]),
            .din_value (in_value[i]),
            .head_tag  (q_tag[i]),
            .head_value(q_value[i]),
            .count     (q_count[i]),
            .ovf       (ovf[i])
        );
    end

    assign issue_stall = !rst && (|near_full);

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid    <= 1'b0;
            cdb_tag      <= '0;
            cdb_value    <= '0;
            cdb_src      <= '0;
            last         <= 2'd2;
            overflow_err <= 1'b0;
        end else if (rdy) begin
            if (|ovf)
                overflow_err <= 1'b1;
            if (flush) begin
                cdb_valid <= 1'b0;
            end else if (grant_vld) begin
                cdb_valid <= 1'b1;
                cdb_tag   <= sel_tag;
                cdb_value <= sel_value;
                cdb_src   <= grant;
                last      <= grant;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter (default build, bypass disabled).
// Expected broadcasts are pushed into a scoreboard queue as stimulus is
// driven; a negedge monitor pops and compares every new CDB broadcast.
module tb_cdb_arbiter;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst, rdy, flush;
    logic             alu1_valid, alu2_valid, lsb_valid;
    logic [TAG_W-1:0] alu1_tag, alu2_tag, lsb_tag;
    logic [31:0]      alu1_value, alu2_value, lsb_value;
    logic             cdb_valid, issue_stall, overflow_err;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;
    logic [1:0]       cdb_src;

    int          checks = 0;
    int          errors = 0;
    logic [37:0] sb[$];
    logic [37:0] mon_exp;
    logic        rdy_q = 1'b0;
    logic        rst_q = 1'b1;

    // ALU1-only-contended table: valid bits {lsb,alu2,alu1}, tags, stall.
    logic [2:0] s3_v  [10] = '{3'b110, 3'b011, 3'b101, 3'b011, 3'b000,
                               3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [3:0] s3_ta [10] = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0};
    logic [3:0] s3_tb [10] = '{4, 5, 0, 6, 0, 0, 0, 0, 0, 0};
    logic [3:0] s3_tc [10] = '{7, 0, 8, 0, 0, 0, 0, 0, 0, 0};
    logic       s3_st [10] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

    cdb_arbiter #(.FIFO_DEPTH(4), .STALL_MARGIN(2), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .alu1_valid(alu1_valid), .alu1_tag(alu1_tag), .alu1_value(alu1_value),
        .alu2_valid(alu2_valid), .alu2_tag(alu2_tag), .alu2_value(alu2_value),
        .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_value(lsb_value),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_src(cdb_src), .issue_stall(issue_stall), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] vf(input int s, input logic [3:0] t);
        return 32'h0C0D_0000 | (32'(s) << 8) | 32'(t);
    endfunction

    task automatic push(input int s, input logic [3:0] t);
        sb.push_back({2'(s), t, vf(s, t)});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [2:0] v, input logic [3:0] t0, input logic [3:0] t1,
                          input logic [3:0] t2);
        alu1_valid = v[0]; alu1_tag = t0; alu1_value = vf(0, t0);
        alu2_valid = v[1]; alu2_tag = t1; alu2_value = vf(1, t1);
        lsb_valid  = v[2]; lsb_tag  = t2; lsb_value  = vf(2, t2);
    endtask

    task automatic do_reset;
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        set_in(3'b000, 0, 0, 0);
        tick;
        tick;
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_tag",   64'(cdb_tag), 64'd0);
        chk("rst_value", 64'(cdb_value), 64'd0);
        chk("rst_src",   64'(cdb_src), 64'd0);
        chk("rst_ovf",   64'(overflow_err), 64'd0);
        chk("rst_stall", 64'(issue_stall), 64'd0);
        chk("sb_empty_at_rst", 64'(sb.size()), 64'd0);
        rst = 1'b0;
    endtask

    // Monitor: every new broadcast (edge with rdy high, out of reset) is
    // matched against the head of the scoreboard.
    always @(posedge clk) begin
        rdy_q <= rdy;
        rst_q <= rst;
    end

    always @(negedge clk) begin
        if (!rst_q && rdy_q && cdb_valid) begin
            if (sb.size() == 0) begin
                chk("bcast_extra", 64'(cdb_valid), 64'd0);
            end else begin
                mon_exp = sb.pop_front();
                chk("bcast", 64'({cdb_src, cdb_tag, cdb_value}), 64'(mon_exp));
            end
        end
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        set_in(3'b000, 0, 0, 0);
        do_reset;

        // Single ALU1 result: one queue stage of latency, one-cycle pulse.
        set_in(3'b001, 3, 0, 0);
        alu1_value = 32'h11;
        sb.push_back({2'd0, 4'd3, 32'h11});
        tick;
        set_in(3'b000, 0, 0, 0);
        chk("lat_e0_valid", 64'(cdb_valid), 64'd0);
        tick;
        chk("lat_e1_valid", 64'(cdb_valid), 64'd1);
        chk("lat_tag",   64'(cdb_tag), 64'd3);
        chk("lat_value", 64'(cdb_value), 64'h11);
        chk("lat_src",   64'(cdb_src), 64'd0);
        tick;
        chk("single_pulse", 64'(cdb_valid), 64'd0);
        tick;

        // Overflow: last grant was ALU1, so ALU1 loses the first two rounds
        // and its sixth result finds a full queue.
        push(1, 7); push(2, 9); push(0, 1); push(1, 8); push(2, 10);
        push(0, 2); push(0, 3); push(0, 4); push(0, 5);
        set_in(3'b111, 1, 7, 9);
        tick;
        set_in(3'b111, 2, 8, 10);
        tick;
        set_in(3'b001, 3, 0, 0);
        tick;
        set_in(3'b001, 4, 0, 0);
        tick;
        set_in(3'b001, 5, 0, 0);
        tick;
        chk("ovf_before", 64'(overflow_err), 64'd0);
        set_in(3'b001, 6, 0, 0);
        tick;
        chk("ovf_set", 64'(overflow_err), 64'd1);
        chk("stall_full", 64'(issue_stall), 64'd1);
        set_in(3'b000, 0, 0, 0);
        repeat (6) tick;
        chk("ovf_sticky", 64'(overflow_err), 64'd1);

        // Three-way contention then RR continuation.
        do_reset;
        push(0, 1); push(1, 2); push(2, 5);
        set_in(3'b111, 1, 2, 5);
        tick;
        set_in(3'b000, 0, 0, 0);
        chk("s2_stall", 64'(issue_stall), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("s2_back2back", 64'(cdb_valid), 64'd1);
        end
        tick;
        chk("s2_idle", 64'(cdb_valid), 64'd0);
        push(1, 7);
        set_in(3'b010, 0, 7, 0);
        tick;
        set_in(3'b000, 0, 0, 0);
        repeat (3) tick;
        push(2, 10); push(0, 8); push(1, 9);
        set_in(3'b111, 8, 9, 10);
        tick;
        set_in(3'b000, 0, 0, 0);
        repeat (5) tick;

        // ALU1 under contention: stall tracks the ALU1 count, no overflow.
        do_reset;
        push(1, 4); push(2, 7); push(0, 1); push(1, 5);
        push(2, 8); push(0, 2); push(1, 6); push(0, 3);
        for (int i = 0; i < 10; i++) begin
            set_in(s3_v[i], s3_ta[i], s3_tb[i], s3_tc[i]);
            tick;
            chk($sformatf("s3_stall_%0d", i), 64'(issue_stall), 64'(s3_st[i]));
        end
        set_in(3'b000, 0, 0, 0);
        chk("s3_no_ovf", 64'(overflow_err), 64'd0);

        // Flush with loaded queues and a same-edge ALU2 result.
        do_reset;
        push(0, 1); push(1, 2);
        set_in(3'b111, 1, 2, 3);
        tick;
        set_in(3'b111, 4, 5, 6);
        tick;
        set_in(3'b111, 7, 8, 9);
        tick;
        chk("pre_flush_stall", 64'(issue_stall), 64'd1);
        set_in(3'b010, 0, 10, 0);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        set_in(3'b000, 0, 0, 0);
        chk("flush_valid", 64'(cdb_valid), 64'd0);
        chk("flush_stall", 64'(issue_stall), 64'd0);
        chk("flush_ovf",   64'(overflow_err), 64'd0);
        repeat (4) tick;
        // Last grant before the flush was ALU2, so LSB leads next.
        push(2, 13); push(0, 11); push(1, 12);
        set_in(3'b111, 11, 12, 13);
        tick;
        set_in(3'b000, 0, 0, 0);
        repeat (4) tick;

        // Freeze: rdy low holds outputs and ignores inputs.
        push(2, 3); push(0, 1); push(1, 2);
        set_in(3'b111, 1, 2, 3);
        tick;
        set_in(3'b000, 0, 0, 0);
        tick;
        chk("pre_frz_src", 64'(cdb_src), 64'd2);
        rdy = 1'b0;
        set_in(3'b001, 9, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("frz_valid", 64'(cdb_valid), 64'd1);
            chk("frz_tag",   64'(cdb_tag), 64'd3);
            chk("frz_src",   64'(cdb_src), 64'd2);
        end
        rdy = 1'b1;
        set_in(3'b000, 0, 0, 0);
        tick;
        chk("resume_src1", 64'(cdb_src), 64'd0);
        chk("resume_tag1", 64'(cdb_tag), 64'd1);
        tick;
        chk("resume_src2", 64'(cdb_src), 64'd1);
        chk("resume_tag2", 64'(cdb_tag), 64'd2);
        tick;
        chk("resume_idle", 64'(cdb_valid), 64'd0);

        repeat (3) tick;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
